// File: rtl/gamepad_input_conditioner.sv
// gamepad_input_conditioner
// Conditions decoded gamepad button levels for game logic: per-lane
// debounce on sample ticks, one-clk press/release pulses, long-hold
// detection, and a forced release of every lane when the pad is absent.
// Optional auto-repeat of o_press while held: define GAMEPAD_AUTOREPEAT_EN.
module gamepad_input_conditioner #(
  parameter int NUM_BTN        = 4,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int HOLD_TICKS     = 12,
  parameter int REPEAT_TICKS   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_sample_tick,
  input  logic               i_present,
  input  logic [NUM_BTN-1:0] i_buttons,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_press,
  output logic [NUM_BTN-1:0] o_release,
  output logic [NUM_BTN-1:0] o_hold
);

  // Last count value before a differing level is accepted.
  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_TICKS - 1);
  // Saturation value of the hold counter; o_hold is high at this value.
  localparam logic [7:0] HOLD_MAX = 8'(HOLD_TICKS);
`ifdef GAMEPAD_AUTOREPEAT_EN
  // Repeat counter wraps (and pulses) after this value.
  localparam logic [7:0] REP_LAST = 8'(REPEAT_TICKS - 1);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_lane
      logic       level_reg;
      logic       press_reg;
      logic       release_reg;
      logic [3:0] deb_cnt_reg;
      logic [7:0] hold_cnt_reg;
      logic       eff;
      logic       accept;
      logic       hold_now;
`ifdef GAMEPAD_AUTOREPEAT_EN
      logic [7:0] rep_cnt_reg;
`endif

      // A missing pad reads as every button released.
      assign eff      = i_buttons[gi] & i_present;
      // The differing level has persisted long enough to be taken on a tick.
      assign accept   = (eff != level_reg) && (deb_cnt_reg >= DEB_LAST);
      assign hold_now = (hold_cnt_reg == HOLD_MAX);

      // Per-lane debounce, pulse, hold (and optional repeat) state.
      always_ff @(posedge clk) begin
        if (rst) begin
          level_reg    <= 1'b0;
          press_reg    <= 1'b0;
          release_reg  <= 1'b0;
          deb_cnt_reg  <= '0;
          hold_cnt_reg <= '0;
`ifdef GAMEPAD_AUTOREPEAT_EN
          rep_cnt_reg  <= '0;
`endif
        end else begin
          // Pulses live for exactly one clock.
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          if (!i_present && level_reg) begin
            // Pad unplugged: drop the lane at once, silently.
            level_reg    <= 1'b0;
            hold_cnt_reg <= '0;
            deb_cnt_reg  <= '0;
          end else if (i_sample_tick) begin
            if (eff == level_reg) begin
              deb_cnt_reg <= '0;
            end else if (!accept) begin
              deb_cnt_reg <= deb_cnt_reg + 4'd1;
            end else begin
              level_reg   <= eff;
              deb_cnt_reg <= '0;
              if (eff) press_reg   <= 1'b1;
              else     release_reg <= 1'b1;
            end
            // Hold time accumulates only while the debounced level is high;
            // it clears on the same edge that accepts the release.
            if (level_reg) begin
              if (accept)         hold_cnt_reg <= '0;
              else if (!hold_now) hold_cnt_reg <= hold_cnt_reg + 8'd1;
            end
          end
`ifdef GAMEPAD_AUTOREPEAT_EN
          // Repeat ticks run only while held; a wrap re-fires o_press.
          if ((!i_present && level_reg) || !level_reg || !hold_now ||
              (i_sample_tick && accept)) begin
            rep_cnt_reg <= '0;
          end else if (i_sample_tick) begin
            if (rep_cnt_reg >= REP_LAST) begin
              rep_cnt_reg <= '0;
              press_reg   <= 1'b1;
            end else begin
              rep_cnt_reg <= rep_cnt_reg + 8'd1;
            end
          end
`endif
        end
      end

      assign o_level[gi]   = level_reg;
      assign o_press[gi]   = press_reg;
      assign o_release[gi] = release_reg;
      assign o_hold[gi]    = hold_now;
    end
  endgenerate

endmodule
